// File: rtl/gray_pkg.sv
// gray_pkg: shared FSM encoding, error-count ceiling and Gray-to-binary helper for the Gray stream blocks
package gray_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, LOST = 2'd2} state_e;
  localparam logic [7:0] ERR_CNT_MAX = 8'd255;
  // Each binary bit is the XOR of its Gray bit and all higher Gray bits; unused upper bits must be zero.
  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/gray_step_check.sv
// gray_step_check: decodes a Gray word and flags whether it is a legal +1 step from the previous word.
// Ports: prev_g_i previous Gray word, g_i current Gray word, bin_o binary of g_i, good_o legal +1 step.
module gray_step_check
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_g_i,
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] bin_o,
  output logic             good_o
);
  logic [WIDTH-1:0] prev_bin;
  assign bin_o    = WIDTH'(gray2bin(8'(g_i)));
  assign prev_bin = WIDTH'(gray2bin(8'(prev_g_i)));
  // Width-limited add makes the all-ones to zero wrap count as a good step.
  assign good_o   = ($countones(g_i ^ prev_g_i) == 1) && (bin_o == prev_bin + WIDTH'(1));
endmodule

// File: rtl/gray_stream_decoder.sv
// gray_stream_decoder: accepts Gray words over valid/ready, returns registered binary with step-error and lock tracking.
// Ports: clk/rst (sync active-high), in_valid/in_gray/in_ready upstream handshake,
// out_valid/out_ready/out_bin/out_step_err downstream result, sync_ok high in TRACK, err_count saturating bad-step count.
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int ERR_LOSE   = 3,
  parameter int GOOD_REACQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gray,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err,
  output logic             sync_ok,
  output logic [7:0]       err_count
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_g_q, out_bin_q, bin;
  logic [7:0]       bad_run_q, bad_run_d, good_run_q, good_run_d, err_cnt_q, err_cnt_d;
  logic             out_valid_q, out_step_err_q, good, accept, step_err;

  gray_step_check #(.WIDTH(WIDTH)) u_check (
    .prev_g_i(prev_g_q),
    .g_i     (in_gray),
    .bin_o   (bin),
    .good_o  (good)
  );

  assign in_ready     = !out_valid_q || out_ready;
  assign accept       = in_valid && in_ready;
  assign out_valid    = out_valid_q;
  assign out_bin      = out_bin_q;
  assign out_step_err = out_step_err_q;
  assign sync_ok      = state_q == TRACK;
  assign err_count    = err_cnt_q;
  // The first word after reset has no predecessor, so it can never be a step error.
  assign step_err     = accept && state_q != IDLE && !good;

  always_comb begin
    state_d    = state_q;
    bad_run_d  = bad_run_q;
    good_run_d = good_run_q;
    err_cnt_d  = (step_err && err_cnt_q != ERR_CNT_MAX) ? err_cnt_q + 8'd1 : err_cnt_q;
    if (accept) begin
      case (state_q)
        IDLE: state_d = TRACK;
        TRACK: begin
          bad_run_d = good ? 8'd0 : bad_run_q + 8'd1;
          if (!good && bad_run_q + 8'd1 >= 8'(ERR_LOSE)) begin
            state_d   = LOST;
            bad_run_d = 8'd0;
          end
        end
        LOST: begin
          good_run_d = good ? good_run_q + 8'd1 : 8'd0;
          if (good && good_run_q + 8'd1 >= 8'(GOOD_REACQ)) begin
            state_d    = TRACK;
            bad_run_d  = 8'd0;
            good_run_d = 8'd0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      prev_g_q       <= '0;
      out_bin_q      <= '0;
      out_step_err_q <= 1'b0;
      out_valid_q    <= 1'b0;
      bad_run_q      <= 8'd0;
      good_run_q     <= 8'd0;
      err_cnt_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      bad_run_q   <= bad_run_d;
      good_run_q  <= good_run_d;
      err_cnt_q   <= err_cnt_d;
      out_valid_q <= accept || (out_valid_q && !out_ready);
      if (accept) begin
        prev_g_q       <= in_gray;
        out_bin_q      <= bin;
        out_step_err_q <= step_err;
      end
    end
  end
endmodule

// File: tb/tb_gray_stream_decoder.sv
// tb_gray_stream_decoder: directed scoreboard bench for gray_stream_decoder
module tb_gray_stream_decoder;
  typedef struct {
    logic [3:0] bin;
    logic       err;
    logic       sync;
    logic [7:0] cnt;
  } exp_t;
  logic       clk, rst, in_valid, in_ready, out_valid, out_ready, out_step_err, sync_ok;
  logic [3:0] in_gray, out_bin;
  logic [7:0] err_count;
  int         checks, failures;
  exp_t       q[$];
  logic [3:0] m_prev;
  int         m_state, m_bad, m_good, m_cnt;
  logic [3:0] full_seq[17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

  gray_stream_decoder #(.WIDTH(4), .ERR_LOSE(3), .GOOD_REACQ(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_gray(in_gray), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
    .out_step_err(out_step_err), .sync_ok(sync_ok), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    assert (act === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic void model_accept(input logic [3:0] g);
    exp_t e;
    logic good;
    e.bin = g2b(g);
    e.err = 1'b0;
    if (m_state == 0) m_state = 1;
    else begin
      good  = ($countones(g ^ m_prev) == 1) && (e.bin == 4'(g2b(m_prev) + 4'd1));
      e.err = !good;
      if (!good && m_cnt < 255) m_cnt++;
      if (m_state == 1) begin
        m_bad = good ? 0 : m_bad + 1;
        if (m_bad >= 3) m_state = 2;
      end else begin
        m_good = good ? m_good + 1 : 0;
        if (m_good >= 2) begin
          m_state = 1;
          m_bad   = 0;
          m_good  = 0;
        end
      end
    end
    m_prev = g;
    e.sync = m_state == 1;
    e.cnt  = 8'(m_cnt);
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 8'd1, 8'd0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("out_bin", 8'(out_bin), 8'(e.bin));
        chk("out_step_err", 8'(out_step_err), 8'(e.err));
        chk("sync_ok", 8'(sync_ok), 8'(e.sync));
        chk("err_count", err_count, e.cnt);
      end
    end
  end

  task automatic send(input logic [3:0] g);
    bit acc = 0;
    int n = 0;
    in_valid = 1'b1;
    in_gray  = g;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      if (acc) model_accept(g);
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("accept_timeout", 8'd0, 8'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    m_state = 0; m_bad = 0; m_good = 0; m_cnt = 0; m_prev = 4'h0;
    @(negedge clk);
    chk({tag, "_valid"}, 8'(out_valid), 8'd0);
    chk({tag, "_bin"}, 8'(out_bin), 8'd0);
    chk({tag, "_err"}, 8'(out_step_err), 8'd0);
    chk({tag, "_sync"}, 8'(sync_ok), 8'd0);
    chk({tag, "_cnt"}, err_count, 8'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk = 0; rst = 1; in_valid = 0; in_gray = 0; out_ready = 1;
    checks = 0; failures = 0;
    idle(2);
    do_reset("rst0");
    foreach (full_seq[i]) send(full_seq[i]);
    idle(3);
    do_reset("rst1");
    send(4'h0); send(4'h1); send(4'h3); send(4'h6);
    idle(3);
    do_reset("rst2");
    send(4'h0); send(4'h5); send(4'h5); send(4'h5); send(4'h4); send(4'hC); send(4'hD);
    idle(3);
    chk("lose_reacq_cnt", err_count, 8'd3);
    do_reset("rst3");
    out_ready = 1'b0;
    send(4'h0);
    fork
      send(4'h1);
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("bp_in_ready", 8'(in_ready), 8'd0);
          chk("bp_frozen_bin", 8'(out_bin), 8'd0);
          chk("bp_valid", 8'(out_valid), 8'd1);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    send(4'h3);
    idle(3);
    do_reset("rst4");
    send(4'h0); send(4'h1); send(4'h3);
    idle(3);
    do_reset("rst_mid");
    send(4'h2); send(4'h6);
    idle(3);
    do_reset("rst5");
    send(4'h0);
    for (int i = 0; i < 300; i++) send(4'h0);
    idle(3);
    chk("sat_cnt", err_count, 8'd255);
    chk("sat_sync", 8'(sync_ok), 8'd0);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
